rice_core_if_stage: RTL



---
 rtl/rice_core_if_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rice_core_if_stage.sv
// rice_core_if_stage: instruction-fetch stage of the rice core pipeline.
// Keeps the fetch PC, issues word fetches under a credit limit, tags each
// request with its PC, buffers returned words and presents the IF result to
// decode. Flush redirects fetch and drops responses to pre-flush requests.
// Optional feature macro: RICE_CORE_IF_PREFETCH_EN (defined: two credits,
// one prefetch ahead; undefined: a single request outstanding or buffered).
module rice_core_if_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [31:0]     o_if_inst,
  output logic            o_inst_request_valid,
  input  logic            i_inst_request_ready,
  output logic [XLEN-1:0] o_inst_address,
  input  logic            i_inst_response_valid,
  input  logic [31:0]     i_inst_response_data
);

`ifdef RICE_CORE_IF_PREFETCH_EN
  localparam int unsigned MAX = 2;
`else
  localparam int unsigned MAX = 1;
`endif
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } if_entry_t;

  logic [XLEN-1:0]  r_fetch_pc, w_fetch_pc_n;
  logic [CNT_W-1:0] r_out_cnt, w_out_cnt_n;
  logic [CNT_W-1:0] r_disc_cnt, w_disc_cnt_n;
  logic [CNT_W-1:0] r_buf_cnt, w_buf_cnt_n;
  logic [CNT_W-1:0] r_tag_cnt, w_tag_cnt_n;
  if_entry_t        r_buf [DEPTH];
  if_entry_t        w_buf_n [DEPTH];
  logic [XLEN-1:0]  r_tag [DEPTH];
  logic [XLEN-1:0]  w_tag_n [DEPTH];
  logic             r_if_valid, w_if_valid_n;
  logic [XLEN-1:0]  r_if_pc, w_if_pc_n;
  logic [31:0]      r_if_inst, w_if_inst_n;

  logic             w_req_valid;
  logic             w_accept;
  logic             w_resp;
  logic             w_keep;
  logic             w_load;
  if_entry_t        w_resp_entry;
  logic [CNT_W-1:0] w_tcnt;
  logic [CNT_W-1:0] w_bcnt;

  // Request credit: outstanding plus buffered words may not exceed MAX.
  assign w_req_valid  = !i_rst && !i_flush &&
                        ((SUM_W'(r_out_cnt) + SUM_W'(r_buf_cnt)) < SUM_W'(MAX));
  assign w_accept     = w_req_valid && i_inst_request_ready;
  // Responses with nothing outstanding (stale bus traffic after reset) are ignored.
  assign w_resp       = i_inst_response_valid && (r_out_cnt != '0);
  assign w_keep       = w_resp && !i_flush && (r_disc_cnt == '0);
  assign w_load       = !r_if_valid || !i_stall;
  assign w_resp_entry = '{pc: r_tag[0], inst: i_inst_response_data};

  // Next-state: flush first, otherwise counters, tag queue, buffer and IF result.
  always_comb begin
    w_fetch_pc_n = r_fetch_pc;
    w_out_cnt_n  = r_out_cnt;
    w_disc_cnt_n = r_disc_cnt;
    w_buf_n      = r_buf;
    w_buf_cnt_n  = r_buf_cnt;
    w_tag_n      = r_tag;
    w_tag_cnt_n  = r_tag_cnt;
    w_if_valid_n = r_if_valid;
    w_if_pc_n    = r_if_pc;
    w_if_inst_n  = r_if_inst;
    w_tcnt       = r_tag_cnt;
    w_bcnt       = r_buf_cnt;
    if (i_flush) begin
      w_fetch_pc_n = i_flush_pc;
      w_out_cnt_n  = r_out_cnt - CNT_W'(w_resp);
      w_disc_cnt_n = r_out_cnt - CNT_W'(w_resp);
      w_buf_cnt_n  = '0;
      w_tag_cnt_n  = '0;
      w_if_valid_n = 1'b0;
    end else begin
      if (w_accept) begin
        w_fetch_pc_n = r_fetch_pc + XLEN'(4);
      end
      w_out_cnt_n = r_out_cnt + CNT_W'(w_accept) - CNT_W'(w_resp);
      if (w_resp && (r_disc_cnt != '0)) begin
        w_disc_cnt_n = r_disc_cnt - CNT_W'(1);
      end
      // Tag queue: pop head for a kept response, append PC of an accepted request.
      if (w_keep) begin
        w_tag_n[0] = r_tag[1];
        w_tcnt     = r_tag_cnt - CNT_W'(1);
      end
      if (w_accept) begin
        w_tag_n[w_tcnt[0]] = r_fetch_pc;
        w_tcnt             = w_tcnt + CNT_W'(1);
      end
      w_tag_cnt_n = w_tcnt;
      // IF result takes buffer head, else bypasses the arriving response.
      if (w_load) begin
        if (r_buf_cnt != '0) begin
          w_if_valid_n = 1'b1;
          w_if_pc_n    = r_buf[0].pc;
          w_if_inst_n  = r_buf[0].inst;
          w_buf_n[0]   = r_buf[1];
          w_bcnt       = r_buf_cnt - CNT_W'(1);
        end else if (w_keep) begin
          w_if_valid_n = 1'b1;
          w_if_pc_n    = w_resp_entry.pc;
          w_if_inst_n  = w_resp_entry.inst;
        end else begin
          w_if_valid_n = 1'b0;
        end
      end
      if (w_keep && !(w_load && (r_buf_cnt == '0))) begin
        w_buf_n[w_bcnt[0]] = w_resp_entry;
        w_bcnt             = w_bcnt + CNT_W'(1);
      end
      w_buf_cnt_n = w_bcnt;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
      r_buf_cnt  <= '0;
      r_tag_cnt  <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_buf[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_n;
      r_out_cnt  <= w_out_cnt_n;
      r_disc_cnt <= w_disc_cnt_n;
      r_buf_cnt  <= w_buf_cnt_n;
      r_tag_cnt  <= w_tag_cnt_n;
      r_if_valid <= w_if_valid_n;
      r_if_pc    <= w_if_pc_n;
      r_if_inst  <= w_if_inst_n;
      r_buf      <= w_buf_n;
      r_tag      <= w_tag_n;
    end
  end

  assign o_if_valid           = r_if_valid;
  assign o_if_pc              = r_if_pc;
  assign o_if_inst            = r_if_inst;
  assign o_inst_request_valid = w_req_valid;
  assign o_inst_address       = r_fetch_pc;

endmodule
